// File: rtl/concat_if_pkg.sv
// Shared types for the two-requester concat / if-else result slot.
package concat_if_pkg;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] c;
    logic       cond;
  } op_t;

  typedef struct packed {
    logic [15:0] concat;
    logic [7:0]  if_else;
  } res_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Result of one operation: {a,b,c} and cond ? c : {a,b}
  function automatic res_t compute(op_t op);
    res_t r;
    r.concat  = {op.a, op.b, op.c};
    r.if_else = op.cond ? op.c : {op.a, op.b};
    return r;
  endfunction

endpackage

// File: rtl/concat_if_arb_if.sv
// Request/result bus of concat_if_arb; slave is the block's view.
interface concat_if_arb_if;
  import concat_if_pkg::*;

  logic             req0_valid, req0_ready;
  logic [3:0]       req0_a, req0_b;
  logic [7:0]       req0_c;
  logic             req0_cond;
  logic             req1_valid, req1_ready;
  logic [3:0]       req1_a, req1_b;
  logic [7:0]       req1_c;
  logic             req1_cond;
  logic             out_valid, out_ready;
  logic [15:0]      out_concat;
  logic [7:0]       out_if_else;
  logic             out_src;
  logic [CNT_W-1:0] cnt0, cnt1;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c, req0_cond,
    input  req1_valid, req1_a, req1_b, req1_c, req1_cond,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_concat, out_if_else, out_src, cnt0, cnt1
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_c, req0_cond,
    output req1_valid, req1_a, req1_b, req1_c, req1_cond,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_concat, out_if_else, out_src, cnt0, cnt1
  );

endinterface

// File: rtl/concat_if_arb_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the favoured requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  // Grant: lone requester wins, contention resolved by pointer
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer moves to the loser after each grant, holds otherwise
  always_ff @(posedge clk) begin
    if (rst)         ptr <= 1'b0;
    else if (gnt[0]) ptr <= 1'b1;
    else if (gnt[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/concat_if_arb.sv
// Single-slot result register fed by a round-robin pick of two requesters.
module concat_if_arb
  import concat_if_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  concat_if_arb_if.slave  bus
);

  state_t                 state, state_nxt;
  logic                   slot_free, en, grant;
  logic [1:0]             req, gnt;
  op_t                    op0, op1, op_sel;
  res_t                   res, res_q;
  logic                   src_q;
  logic [1:0][CNT_W-1:0]  cnt;

  // Slot accepts new work when empty or being drained this cycle;
  // reset masks grants so no handshake happens while rst is high.
  assign slot_free = (state == EMPTY) || bus.out_ready;
  assign en        = slot_free && !rst;
  assign req       = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (en),
    .gnt (gnt)
  );

  assign grant          = |gnt;
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  assign op0 = '{a: bus.req0_a, b: bus.req0_b, c: bus.req0_c, cond: bus.req0_cond};
  assign op1 = '{a: bus.req1_a, b: bus.req1_b, c: bus.req1_c, cond: bus.req1_cond};

  // Operand mux toward the granted requester
  always_comb begin
    op_sel = op0;
    if (gnt[1]) op_sel = op1;
  end

  assign res = compute(op_sel);

  // Slot state register
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Slot next state: fill on grant, drain on consume without refill
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (bus.out_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Result data loads only on grant; holds after drain
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      src_q <= 1'b0;
    end else if (grant) begin
      res_q <= res;
      src_q <= gnt[1];
    end
  end

  // Saturating per-requester accept counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (gnt[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign bus.out_valid   = (state == FULL);
  assign bus.out_concat  = res_q.concat;
  assign bus.out_if_else = res_q.if_else;
  assign bus.out_src     = src_q;
  assign bus.cnt0        = cnt[0];
  assign bus.cnt1        = cnt[1];

endmodule

// File: tb/tb_concat_if_arb.sv
// Bench for concat_if_arb: directed vector table, corner sequences,
// then random traffic against a behavioural slot model.
module tb_concat_if_arb;
  import concat_if_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  concat_if_arb_if bus();

  concat_if_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model of the slot
  bit        m_valid;
  bit [15:0] m_concat;
  bit [7:0]  m_ifelse;
  bit        m_src;
  int        m_cnt [2];
  int        m_pref;      // requester favoured on contention
  logic      obs_r0, obs_r1;

  typedef struct {
    logic v0; logic [3:0] a0, b0; logic [7:0] c0; logic k0;
    logic v1; logic [3:0] a1, b1; logic [7:0] c1; logic k1;
    logic ordy;
    logic r0, r1, ov; logic [15:0] cat; logic [7:0] ie; logic src;
    logic [7:0] n0, n1;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] c, input logic k);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_c = c; bus.req0_cond = k;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_c = c; bus.req1_cond = k;
    end
  endtask

  // Who the rules say gets the grant with the inputs currently driven
  function automatic int m_grant();
    if (rst) return -1;
    if (m_valid && !bus.out_ready) return -1;
    if (bus.req0_valid && bus.req1_valid) return m_pref;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  // One clock: check readies before the edge, advance model, check outputs after
  task automatic cyc();
    int g;
    logic [3:0] a, b; logic [7:0] c; logic k;
    #3;
    g = m_grant();
    obs_r0 = bus.req0_ready;
    obs_r1 = bus.req1_ready;
    chk("req0_ready", obs_r0, g == 0);
    chk("req1_ready", obs_r1, g == 1);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_concat = 0; m_ifelse = 0; m_src = 0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_pref = 0;
    end else if (g >= 0) begin
      if (g == 0) begin a = bus.req0_a; b = bus.req0_b; c = bus.req0_c; k = bus.req0_cond; end
      else        begin a = bus.req1_a; b = bus.req1_b; c = bus.req1_c; k = bus.req1_cond; end
      m_valid  = 1;
      m_concat = a * 4096 + b * 256 + c;
      m_ifelse = k ? c : a * 16 + b;
      m_src    = (g == 1);
      if (m_cnt[g] < 255) m_cnt[g]++;
      m_pref   = 1 - g;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 0;
    end
    chk("out_valid",   bus.out_valid,   m_valid);
    chk("out_concat",  bus.out_concat,  m_concat);
    chk("out_if_else", bus.out_if_else, m_ifelse);
    chk("out_src",     bus.out_src,     m_src);
    chk("cnt0",        bus.cnt0,        m_cnt[0]);
    chk("cnt1",        bus.cnt1,        m_cnt[1]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    m_valid = 0; m_concat = 0; m_ifelse = 0; m_src = 0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_pref = 0;

    // directed vectors, starting from reset (pointer at requester 0)
    //          v0 a0    b0    c0     k0  v1 a1    b1    c1     k1  ordy r0 r1 ov cat        ie     src n0 n1
    tbl[0] = '{1, 4'hA, 4'h5, 8'h3C, 0,  0, 4'h0, 4'h0, 8'h00, 0,  1,   1, 0, 1, 16'hA53C, 8'hA5, 0, 1, 0};
    tbl[1] = '{1, 4'h1, 4'h2, 8'h34, 0,  1, 4'hF, 4'hE, 8'hF0, 1,  1,   0, 1, 1, 16'hFEF0, 8'hF0, 1, 1, 1};
    tbl[2] = '{1, 4'h1, 4'h2, 8'h34, 0,  1, 4'hF, 4'hE, 8'hF0, 1,  1,   1, 0, 1, 16'h1234, 8'h12, 0, 2, 1};
    tbl[3] = '{1, 4'h1, 4'h2, 8'h34, 0,  1, 4'hF, 4'hE, 8'hF0, 1,  0,   0, 0, 1, 16'h1234, 8'h12, 0, 2, 1};
    tbl[4] = '{1, 4'h1, 4'h2, 8'h34, 0,  1, 4'hF, 4'hE, 8'hF0, 1,  0,   0, 0, 1, 16'h1234, 8'h12, 0, 2, 1};
    tbl[5] = '{1, 4'h1, 4'h2, 8'h34, 0,  1, 4'hF, 4'hE, 8'hF0, 1,  1,   0, 1, 1, 16'hFEF0, 8'hF0, 1, 2, 2};
    tbl[6] = '{0, 4'h1, 4'h2, 8'h34, 0,  0, 4'hF, 4'hE, 8'hF0, 1,  1,   0, 0, 0, 16'hFEF0, 8'hF0, 1, 2, 2};
    tbl[7] = '{0, 4'h0, 4'h0, 8'h00, 0,  1, 4'h3, 4'h4, 8'h55, 0,  0,   0, 1, 1, 16'h3455, 8'h34, 1, 2, 3};

    do_reset();
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst out_concat", bus.out_concat, 16'h0);
    chk("rst cnt0", bus.cnt0, 8'h0);

    for (int i = 0; i < 8; i++) begin
      set_req(0, tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].c0, tbl[i].k0);
      set_req(1, tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].c1, tbl[i].k1);
      bus.out_ready = tbl[i].ordy;
      cyc();
      chk($sformatf("vec%0d r0", i), obs_r0, tbl[i].r0);
      chk($sformatf("vec%0d r1", i), obs_r1, tbl[i].r1);
      chk($sformatf("vec%0d valid", i), bus.out_valid, tbl[i].ov);
      chk($sformatf("vec%0d concat", i), bus.out_concat, tbl[i].cat);
      chk($sformatf("vec%0d if_else", i), bus.out_if_else, tbl[i].ie);
      chk($sformatf("vec%0d src", i), bus.out_src, tbl[i].src);
      chk($sformatf("vec%0d cnt0", i), bus.cnt0, tbl[i].n0);
      chk($sformatf("vec%0d cnt1", i), bus.cnt1, tbl[i].n1);
    end

    // alternating grants under constant contention
    do_reset();
    set_req(0, 1, 4'h6, 4'h7, 8'h89, 0);
    set_req(1, 1, 4'h9, 4'h8, 8'h76, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("alt src", bus.out_src, i % 2);
    end
    chk("alt cnt0", bus.cnt0, 8'd2);
    chk("alt cnt1", bus.cnt1, 8'd2);

    // saturation, then reset while a result is held
    do_reset();
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 4'h2, 4'h4, 8'h66, 1);
    for (int i = 0; i < 300; i++) cyc();
    chk("sat cnt0", bus.cnt0, 8'd255);
    bus.out_ready = 1'b0;
    cyc();
    chk("held valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    cyc();
    chk("rst r0", obs_r0, 1'b0);
    chk("rst r1", obs_r1, 1'b0);
    chk("rst drop valid", bus.out_valid, 1'b0);
    chk("rst cnt0 clr", bus.cnt0, 8'd0);
    rst = 1'b0;
    cyc();
    chk("post rst grant", bus.out_valid, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      set_req(0, ($urandom_range(9) < 7), 4'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
      set_req(1, ($urandom_range(9) < 6), 4'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
      bus.out_ready = ($urandom_range(9) < 6);
      rst = ($urandom_range(199) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
